// File: rtl/mem_copy_dma.sv
// Single-channel word-copy DMA engine driving one request port of dualport_bram.
// Copies num_words words from src_addr to dst_addr in ascending order, one read then one write per word.
module mem_copy_dma #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  idx;
  logic [XLEN-1:0]   data_buf;
  logic              abort_pend;
  logic [ADDR_W-1:0] idx_off;

  // Word index to byte offset; wraps modulo 2^ADDR_W by construction.
  assign idx_off = ADDR_W'(idx) << 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      idx        <= '0;
      data_buf   <= '0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else if (num_words == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              src_q      <= src_addr;
              dst_q      <= dst_addr;
              count_q    <= num_words;
              idx        <= '0;
              words_done <= '0;
              aborted    <= 1'b0;
              abort_pend <= 1'b0;
              busy       <= 1'b1;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= src_addr;
              state      <= RD;
            end
          end
        end
        RD: begin
          if (abort) abort_pend <= 1'b1;
          if (mem_ready) begin
            data_buf <= mem_rdata;
            mem_req  <= 1'b0;
            state    <= RD_GAP;
          end
        end
        RD_GAP: begin
          if (abort) abort_pend <= 1'b1;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= dst_q + idx_off;
          mem_wdata <= data_buf;
          state     <= WR;
        end
        WR: begin
          if (abort) abort_pend <= 1'b1;
          if (mem_ready) begin
            words_done <= words_done + LEN_W'(1);
            idx        <= idx + LEN_W'(1);
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= WR_GAP;
          end
        end
        WR_GAP: begin
          // An abort seen here still counts: the word just written is the last one.
          if (idx == count_q || abort_pend || abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= abort_pend | abort;
            state   <= FIN;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= src_q + idx_off;
            state    <= RD;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized self-checking bench for mem_copy_dma with a stalling bram responder
// and a word-array reference model of the copy.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] num_words;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic        aborted;
  logic [15:0] words_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_copy_dma #(.XLEN(32), .ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_words(num_words), .abort(abort), .busy(busy), .done(done), .err(err),
    .aborted(aborted), .words_done(words_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  bit          rand_stall = 0;
  int          fixed_wait = 1;
  int          beats, done_cnt, err_cnt, busy_cycles, req_cycles, stab_err, gap_err, total_wait;
  int          stall_left, gap_len;
  bit          beat_active = 0;
  bit          had_beat = 0;
  logic [31:0] beat_addr, beat_wdata;
  logic        beat_we;

  // Bram responder and bus monitor: ready/rdata change on the falling edge only.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (mem_req === 1'b1) req_cycles++;
    if (rst === 1'b1 || mem_req !== 1'b1) begin
      if (beat_active && rst !== 1'b1) stab_err++;
      mem_ready   = 1'b0;
      beat_active = 0;
      if (had_beat) gap_len++;
    end else if (!beat_active) begin
      if (had_beat && gap_len != 1) gap_err++;
      beat_active = 1;
      beat_addr   = mem_addr;
      beat_we     = mem_we;
      beat_wdata  = mem_wdata;
      stall_left  = rand_stall ? int'($urandom_range(0, 3)) : fixed_wait;
      total_wait += stall_left;
      mem_ready   = (stall_left == 0);
      mem_rdata   = mem[mem_addr[13:2]];
    end else begin
      if (mem_addr !== beat_addr || mem_we !== beat_we || (beat_we && mem_wdata !== beat_wdata))
        stab_err++;
      stall_left--;
      mem_ready = (stall_left == 0);
      mem_rdata = mem[mem_addr[13:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_ready === 1'b1) begin
      beats++;
      if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
      beat_active = 0;
      had_beat    = 1;
      gap_len     = 0;
    end
  end

  task automatic reset_counters();
    beats = 0; done_cnt = 0; err_cnt = 0; busy_cycles = 0; req_cycles = 0;
    stab_err = 0; gap_err = 0; total_wait = 0; had_beat = 0; gap_len = 0;
  endtask

  // Reference copy: ascending word-by-word read-then-write, so overlap propagates forward.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      ref_mem[(int'(d[13:2]) + i) % 4096] = ref_mem[(int'(s[13:2]) + i) % 4096];
  endtask

  task automatic sync_model();
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
  endtask

  function automatic int image_diffs();
    int mm = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mm++;
    return mm;
  endfunction

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int inject, input logic [31:0] abort_addr,
                          output bit finished, output int cycles);
    @(negedge clk);
    reset_counters();
    src_addr = s; dst_addr = d; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; finished = 0; cycles = -1;
    for (int c = 0; c < 4000 && !finished; c++) begin
      abort = (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === abort_addr);
      if (done === 1'b1) begin
        finished = 1;
        cycles = c;
      end else begin
        if (c == inject) begin
          start = 1'b1; src_addr = 32'h0000_1002; num_words = 16'd3;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, err, aborted, mem_req} !== 5'b0) begin fails++;
      $display("[TB] FAIL reset_flags got busy/done/err/aborted/req=%b exp 00000", {busy, done, err, aborted, mem_req}); end
    checks++; if (words_done !== 16'd0) begin fails++;
      $display("[TB] FAIL reset_words_done got %0d exp 0", words_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    bit fin; int cyc; int bad = 0;
    for (int i = 0; i < 32; i++) begin
      mem[(32'h1000 >> 2) + i] = 32'hCAFE_0000 + i;
      mem[(32'h2000 >> 2) + i] = 32'hDEAD_BEEF;
    end
    sync_model();
    model_copy(32'h1000, 32'h2000, 32);
    rand_stall = 0; fixed_wait = 1;
    run_copy(32'h1000, 32'h2000, 16'd32, 20, 32'h1, fin, cyc);
    checks++; if (fin !== 1'b1) begin fails++; $display("[TB] FAIL basic_done_timeout got no done exp done"); end
    for (int i = 0; i < 32; i++) if (mem[(32'h2000 >> 2) + i] !== 32'hCAFE_0000 + i) bad++;
    checks++; if (bad !== 0) begin fails++; $display("[TB] FAIL basic_dst_data got %0d bad words exp 0", bad); end
    checks++; if (image_diffs() !== 0) begin fails++; $display("[TB] FAIL basic_mem_image got %0d diffs exp 0", image_diffs()); end
    checks++; if (words_done !== 16'd32) begin fails++; $display("[TB] FAIL basic_words_done got %0d exp 32", words_done); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0 || aborted !== 1'b0) begin fails++;
      $display("[TB] FAIL basic_status got done=%0d err=%0d aborted=%b exp 1 0 0", done_cnt, err_cnt, aborted); end
    checks++; if (beats !== 64) begin fails++; $display("[TB] FAIL basic_beats got %0d exp 64", beats); end
    checks++; if (busy_cycles !== 192) begin fails++; $display("[TB] FAIL basic_busy_cycles got %0d exp 192", busy_cycles); end
    checks++; if (gap_err !== 0 || stab_err !== 0) begin fails++;
      $display("[TB] FAIL basic_handshake got gap_err=%0d stab_err=%0d exp 0 0", gap_err, stab_err); end
  endtask

  task automatic test_zero_len();
    bit fin; int cyc;
    run_copy(32'h1000, 32'h2000, 16'd0, -1, 32'h1, fin, cyc);
    checks++; if (fin !== 1'b1 || cyc !== 0) begin fails++;
      $display("[TB] FAIL zero_done_latency got fin=%0d cycles=%0d exp 1 0", fin, cyc); end
    checks++; if (busy_cycles !== 0 || req_cycles !== 0 || err_cnt !== 0 || done_cnt !== 1) begin fails++;
      $display("[TB] FAIL zero_quiet got busy=%0d req=%0d err=%0d done=%0d exp 0 0 0 1", busy_cycles, req_cycles, err_cnt, done_cnt); end
    checks++; if (words_done !== 16'd32) begin fails++; $display("[TB] FAIL zero_words_held got %0d exp 32", words_done); end
  endtask

  task automatic test_misaligned();
    bit fin; int cyc;
    logic [31:0] srcs [2] = '{32'h0000_1002, 32'h0000_1000};
    logic [31:0] dsts [2] = '{32'h0000_2000, 32'h0000_2001};
    for (int k = 0; k < 2; k++) begin
      run_copy(srcs[k], dsts[k], 16'd4, -1, 32'h1, fin, cyc);
      checks++; if (fin !== 1'b1 || cyc !== 0) begin fails++;
        $display("[TB] FAIL misalign%0d_latency got fin=%0d cycles=%0d exp 1 0", k, fin, cyc); end
      checks++; if (err_cnt !== 1 || done_cnt !== 1 || beats !== 0 || req_cycles !== 0 || busy_cycles !== 0) begin fails++;
        $display("[TB] FAIL misalign%0d_status got err=%0d done=%0d beats=%0d req=%0d busy=%0d exp 1 1 0 0 0",
                 k, err_cnt, done_cnt, beats, req_cycles, busy_cycles); end
    end
  endtask

  task automatic test_stall();
    bit fin; int cyc;
    logic [31:0] s, d;
    s = 32'($urandom_range(0, 1000)) << 2;
    d = 32'($urandom_range(2048, 3000)) << 2;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    sync_model();
    model_copy(s, d, 8);
    rand_stall = 1;
    run_copy(s, d, 16'd8, -1, 32'h1, fin, cyc);
    rand_stall = 0;
    checks++; if (fin !== 1'b1) begin fails++; $display("[TB] FAIL stall_done_timeout got no done exp done"); end
    checks++; if (image_diffs() !== 0) begin fails++; $display("[TB] FAIL stall_mem_image got %0d diffs exp 0", image_diffs()); end
    checks++; if (stab_err !== 0) begin fails++; $display("[TB] FAIL stall_stability got %0d violations exp 0", stab_err); end
    checks++; if (gap_err !== 0) begin fails++; $display("[TB] FAIL stall_gap got %0d bad gaps exp 0", gap_err); end
    checks++; if (beats !== 16 || words_done !== 16'd8 || aborted !== 1'b0) begin fails++;
      $display("[TB] FAIL stall_counts got beats=%0d words=%0d aborted=%b exp 16 8 0", beats, words_done, aborted); end
    checks++; if (busy_cycles !== total_wait + 32) begin fails++;
      $display("[TB] FAIL stall_timing got %0d busy cycles exp %0d", busy_cycles, total_wait + 32); end
  endtask

  task automatic test_abort();
    bit fin; int cyc;
    for (int i = 0; i < 16; i++) begin
      mem[(32'h1000 >> 2) + i] = $urandom;
      mem[(32'h2000 >> 2) + i] = 32'hDEAD_BEEF;
    end
    sync_model();
    model_copy(32'h1000, 32'h2000, 6);
    run_copy(32'h1000, 32'h2000, 16'd16, -1, 32'h1000 + 20, fin, cyc);
    checks++; if (fin !== 1'b1) begin fails++; $display("[TB] FAIL abort_done_timeout got no done exp done"); end
    checks++; if (words_done !== 16'd6 || aborted !== 1'b1 || done_cnt !== 1) begin fails++;
      $display("[TB] FAIL abort_status got words=%0d aborted=%b done=%0d exp 6 1 1", words_done, aborted, done_cnt); end
    checks++; if (mem[(32'h2000 >> 2) + 6] !== 32'hDEAD_BEEF) begin fails++;
      $display("[TB] FAIL abort_word6 got %h exp deadbeef", mem[(32'h2000 >> 2) + 6]); end
    checks++; if (image_diffs() !== 0) begin fails++; $display("[TB] FAIL abort_mem_image got %0d diffs exp 0", image_diffs()); end
  endtask

  task automatic test_reset_mid_copy();
    bit fin; bit found = 0; int cyc;
    logic [31:0] orig;
    @(negedge clk);
    reset_counters();
    src_addr = 32'h1000; dst_addr = 32'h2000; num_words = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h200C) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_reach_wr3 got no WR of word 3 exp found"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words_done !== 16'd0) begin fails++;
      $display("[TB] FAIL rstmid_outputs got req=%b busy=%b done=%b words=%0d exp 0 0 0 0", mem_req, busy, done, words_done); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== 0) begin fails++; $display("[TB] FAIL rstmid_no_done got %0d done pulses exp 0", done_cnt); end
    orig = $urandom;
    mem[32'h3000 >> 2] = orig;
    for (int i = 1; i <= 4; i++) mem[(32'h3000 >> 2) + i] = $urandom;
    sync_model();
    model_copy(32'h3000, 32'h3004, 4);
    run_copy(32'h3000, 32'h3004, 16'd4, -1, 32'h1, fin, cyc);
    checks++; if (fin !== 1'b1 || done_cnt !== 1 || words_done !== 16'd4) begin fails++;
      $display("[TB] FAIL rstmid_second_copy got fin=%0d done=%0d words=%0d exp 1 1 4", fin, done_cnt, words_done); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (mem[(32'h3000 >> 2) + i] !== orig) begin fails++;
        $display("[TB] FAIL rstmid_overlap_w%0d got %h exp %h", i, mem[(32'h3000 >> 2) + i], orig); end
    end
    checks++; if (image_diffs() !== 0) begin fails++; $display("[TB] FAIL rstmid_mem_image got %0d diffs exp 0", image_diffs()); end
  endtask

  task automatic test_back_to_back();
    bit fin; int cyc; int n, si, di;
    rand_stall = 1;
    for (int k = 0; k < 4; k++) begin
      n  = $urandom_range(1, 8);
      si = $urandom_range(0, 4080);
      di = ($urandom_range(0, 1) == 1) ? si + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4080));
      sync_model();
      model_copy(32'(si) << 2, 32'(di) << 2, n);
      run_copy(32'(si) << 2, 32'(di) << 2, 16'(n), -1, 32'h1, fin, cyc);
      checks++; if (fin !== 1'b1 || words_done !== 16'(n) || stab_err !== 0 || gap_err !== 0) begin fails++;
        $display("[TB] FAIL b2b%0d_status got fin=%0d words=%0d stab=%0d gap=%0d exp 1 %0d 0 0", k, fin, words_done, stab_err, gap_err, n); end
      checks++; if (image_diffs() !== 0) begin fails++;
        $display("[TB] FAIL b2b%0d_mem_image got %0d diffs exp 0 (src %0d dst %0d n %0d)", k, image_diffs(), si, di, n); end
    end
    rand_stall = 0;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_misaligned();
    test_stall();
    test_abort();
    test_reset_mid_copy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got simulation still running exp finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Single-channel word-copy DMA engine that drives one request port of dualport_bram, typically port B.
- Software or a controller loads source address, destination address and word count, then pulses start.
- The engine copies words in ascending address order using the bram req/we/addr/wdata/rdata/ready handshake.
- Port A stays free for the CPU during the copy.

Parameters:
- XLEN, 32, data word width; equals the bram data width.
- ADDR_W, 32, byte-address width; equals the bram address width.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; sampled with start.
- dst_addr  in  ADDR_W  destination byte address; sampled with start.
- num_words  in  LEN_W  number of words to copy; sampled with start.
- abort  in  1  request early stop.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on a rejected command.
- aborted  out  1  set with done when the copy ended by abort; cleared on the next accepted start.
- words_done  out  LEN_W  count of completed destination writes.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  XLEN  write data.
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  beat-complete indication.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters and buffer cleared. rst mid-copy takes effect at the next edge: mem_req drops immediately, no done pulse, copy abandoned.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE + start:
  - If src_addr[1:0] or dst_addr[1:0] is nonzero: go to FIN with err=1; no memory access.
  - Else if num_words==0: go to FIN; no memory access.
  - Else latch the command, clear words_done and aborted, set busy, go to RD.
- RD:
  - Drive mem_req=1, mem_we=0, mem_addr=src+4*idx.
  - Hold all three stable until the edge on which mem_ready=1.
  - On that edge capture mem_rdata into the data buffer, go to RD_GAP.
- RD_GAP: mem_req=0 for exactly one cycle, then go to WR.
- WR:
  - Drive mem_req=1, mem_we=1, mem_addr=dst+4*idx, mem_wdata=buffer.
  - Hold stable until mem_ready=1.
  - On that edge: words_done+=1, idx+=1, go to WR_GAP.
- WR_GAP: mem_req=0 for one cycle. Then go to FIN if idx==count or an abort is pending; else go to RD.
- FIN: done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
- Handshake rule: mem_req is never withdrawn, and addr/we/wdata never change, while a beat is outstanding (req=1 and ready not yet seen).
- mem_ready while mem_req=0 is ignored.
- Timing:
  - Cycles per word = (rd_wait+1) + 1 + (wr_wait+1) + 1, where wait = cycles with req=1 and ready=0.
  - The first RD cycle is the cycle after start.
- Address arithmetic: the +4*idx offset is added modulo 2^ADDR_W (wraps silently). idx is LEN_W bits.
- Overlap: the copy is strictly ascending, read-then-write per word. With dst>src and overlapping regions, earlier written words propagate forward. This behaviour is defined, not an error.
- Abort:
  - abort in IDLE is ignored.
  - abort in RD/RD_GAP/WR/WR_GAP sets a pending flag.
  - The in-flight word always finishes its write, then FIN with aborted=1.
  - abort arriving together with completion of the last word still sets aborted=1.
- start while busy is ignored: no state change, no err.
- words_done holds its final value after done until the next accepted start.

Test Plan:
- Bram with ready one cycle after req; src=0x1000 holding 0xCAFE0000+i, dst=0x2000 holding 0xDEADBEEF, num_words=32, start -> dst[i]==0xCAFE0000+i for i=0..31, words_done==32, single done pulse, err=0, aborted=0, exactly 64 beats observed.
- num_words=0, start -> done on the next cycle, busy never high, mem_req never asserted.
- src=0x1002, start -> done and err both pulse, no memory beat.
- Copy of 8 words with mem_ready randomly stalled 0-3 cycles -> addr/we/wdata stable throughout every stall, mem_req low exactly one cycle between beats, data correct.
- abort asserted during the RD of word 5 of a 16-word copy -> word 5 still written, words_done==6, aborted=1, dst words 6..15 unchanged.
- rst pulsed during WR of word 3; then a new start with src=0x3000, dst=0x3004, num_words=4 -> after reset mem_req low and busy=0; the second copy ends with dst region equal to the original word at 0x3000 replicated (forward overlap), done=1.
